// File: rtl/mdio_master.sv
// ---------------------------------------------------------------------------
// mdio_master
//   Clause-22 MDIO management master. Accepts one read or write command at a
//   time, serialises the 64-bit frame (preamble, ST, OP, PHYAD, REGAD, TA,
//   DATA) onto mdio_o with an MDC derived from clk, and returns a single-cycle
//   response carrying read data and a turnaround error flag.
//
// Parameters
//   CLK_DIV   clk cycles per MDC half-period (1..255)
//   PHY_ADDR  PHYAD field placed in every frame
//
// Ports
//   clk, reset          clock and asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_write           1 = write (OP 01), 0 = read (OP 10)
//   cmd_reg_addr        REGAD field
//   cmd_wdata           write data, ignored for reads
//   rsp_valid           single-cycle completion pulse
//   rsp_rdata/error     read data and turnaround fault, held until next rsp
//   busy                high from acceptance through the rsp_valid cycle
//   mdc                 management clock
//   mdio_o/oe/i         pad data out, drive enable, data in
// ---------------------------------------------------------------------------
module mdio_master #(
  parameter int         CLK_DIV  = 20,
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [5:0]  bit_q, bit_d;
  logic        write_q, write_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] shift_q, shift_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;
  logic        ready_q, ready_d;
  logic        phase_end;
  logic [63:0] frame;

  // Whole frame with bit 0 at the MSB. For reads the TA/DATA positions are
  // undriven (oe=0), so their mdio_o value is simply left at 1.
  assign frame = {32'hFFFF_FFFF, 2'b01,
                  write_q ? 2'b01 : 2'b10,
                  PHY_ADDR, reg_q,
                  write_q ? 2'b10 : 2'b11,
                  write_q ? wdata_q : 16'hFFFF};

  assign phase_end = (cnt_q == DIV_LAST);

  // Next-state logic: a half-period counter drives phase (low/high) and the
  // bit index; DONE reuses the same counter for its two idle half-periods.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    write_d     = write_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    rerr_d      = rerr_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = SHIFT;
          cnt_d   = 8'd0;
          phase_d = 1'b0;
          bit_d   = 6'd0;
          write_d = cmd_write;
          reg_d   = cmd_reg_addr;
          wdata_d = cmd_wdata;
          shift_d = 16'd0;
          err_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (phase_end) begin
          cnt_d = 8'd0;
          if (!phase_q) begin
            // Last low-phase cycle: this edge is where mdc rises, so it is
            // the sampling point for the PHY-driven bits of a read.
            phase_d = 1'b1;
            if (!write_q) begin
              if (bit_q == 6'd47) begin
                err_d = mdio_i;
              end
              if (bit_q >= 6'd48) begin
                shift_d = {shift_q[14:0], mdio_i};
              end
            end
          end else begin
            phase_d = 1'b0;
            if (bit_q == 6'd63) begin
              state_d = DONE;
              bit_d   = 6'd0;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        if (phase_end) begin
          cnt_d = 8'd0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d     = 1'b0;
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rdata_d     = write_q ? 16'd0 : shift_q;
            rerr_d      = write_q ? 1'b0 : err_q;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  // State registers; ready is registered so it stays low while in reset and
  // rises on the first clock after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      phase_q     <= 1'b0;
      bit_q       <= 6'd0;
      write_q     <= 1'b0;
      reg_q       <= 5'd0;
      wdata_q     <= 16'd0;
      shift_q     <= 16'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 16'd0;
      rerr_q      <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      write_q     <= write_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      rerr_q      <= rerr_d;
      ready_q     <= ready_d;
    end
  end

  // Pad outputs are decoded from registered state only, so reset forces the
  // idle levels immediately and data changes only when bit_q advances.
  assign mdc       = (state_q == SHIFT) && phase_q;
  assign mdio_oe   = (state_q == SHIFT) && ((bit_q < 6'd46) || write_q);
  assign mdio_o    = (state_q == SHIFT) ? frame[6'd63 - bit_q] : 1'b1;
  assign cmd_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = rerr_q;
  assign busy      = (state_q != IDLE) || rsp_valid_q;

endmodule
